jtcontra_snd_cmd: RTL and testbench

// - Command mailbox between main 6809 and sound CPU. Sits downstream of the main CPU block.
// - Main side writes 8-bit sound commands; they are queued in a small FIFO.
// - Each command is presented to the sound CPU as a latched byte with an IRQ/ack/read handshake.
// - Prevents command loss when main writes faster than sound services IRQs; counts drops.

---
 rtl/jtcontra_snd_cmd_pkg.sv | 18 +
 rtl/jtcontra_snd_cmd_if.sv | 25 ++
 rtl/jtcontra_snd_fifo.sv | 67 ++++++
 rtl/jtcontra_snd_cmd.sv | 100 ++++++++++
 tb/tb_jtcontra_snd_cmd.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/jtcontra_snd_cmd_pkg.sv
// Shared definitions for the main-to-sound command mailbox:
// handshake FSM encodings and the drop counter ceiling.
package jtcontra_snd_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IRQ  = 2'd1,
        ST_WAIT = 2'd2
    } snd_state_t;

    localparam logic [7:0] OVF_MAX = 8'hFF;

    // The counter sticks at its ceiling so a flood of writes cannot wrap it back to a small value.
    function automatic logic [7:0] ovf_inc(input logic [7:0] value);
        ovf_inc = (value == OVF_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/jtcontra_snd_cmd_if.sv
// Main-CPU write port and sound-CPU latch/IRQ handshake of the command mailbox.
interface jtcontra_snd_cmd_if;
    logic       main_cen;
    logic       main_we;
    logic [7:0] main_din;
    logic       main_full;
    logic       snd_cen;
    logic       snd_rd;
    logic       snd_irq_ack;
    logic [7:0] snd_dout;
    logic       snd_irqn;
    logic [7:0] ovf_cnt;

    modport master (
        output main_cen, main_we, main_din,
        output snd_cen, snd_rd, snd_irq_ack,
        input  main_full, snd_dout, snd_irqn, ovf_cnt
    );

    modport slave (
        input  main_cen, main_we, main_din,
        input  snd_cen, snd_rd, snd_irq_ack,
        output main_full, snd_dout, snd_irqn, ovf_cnt
    );
endinterface

// File: rtl/jtcontra_snd_fifo.sv
// Show-ahead synchronous FIFO holding main-CPU commands until the sound side latches them.
// The full flag is registered, so a push is judged against the count before any same-cycle pop.
module jtcontra_snd_fifo #(
    parameter int FIFO_AW = 2,
    parameter int DW      = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               push,
    input  logic               pop,
    input  logic [DW-1:0]      din,
    output logic [DW-1:0]      dout,
    output logic               empty,
    output logic               full,
    output logic [FIFO_AW:0]   count
);

    localparam logic [FIFO_AW:0]   DEPTH   = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    logic [DW-1:0]      mem [0:(1 << FIFO_AW) - 1];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   cnt;
    logic [FIFO_AW:0]   cnt_next;
    logic               full_r;
    logic               do_push;
    logic               do_pop;

    assign do_push = push & ~full_r;
    assign do_pop  = pop & (cnt != '0);

    always_comb begin
        cnt_next = cnt;
        case ({do_push, do_pop})
            2'b10:   cnt_next = cnt + CNT_ONE;
            2'b01:   cnt_next = cnt - CNT_ONE;
            default: cnt_next = cnt;
        endcase
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full_r <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            cnt    <= cnt_next;
            full_r <= (cnt_next == DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign full  = full_r;
    assign count = cnt;

endmodule

// File: rtl/jtcontra_snd_cmd.sv
// Sound command mailbox: queues main-CPU command bytes and hands them one at a time
// to the sound CPU through a registered latch with IRQ / ack / read handshake.
module jtcontra_snd_cmd
    import jtcontra_snd_cmd_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rstn,
    jtcontra_snd_cmd_if.slave  bus
);

    snd_state_t       state;
    snd_state_t       state_next;
    logic             pop;
    logic             irq_release;
    logic             push_req;
    logic             drop;
    logic             has_cmd;
    logic [7:0]       fifo_head;
    logic             fifo_empty;
    logic             fifo_full;
    logic [FIFO_AW:0] fifo_count;
    logic [7:0]       dout_r;
    logic             irqn_r;
    logic [7:0]       ovf_r;

    assign push_req = bus.main_cen & bus.main_we;
    assign drop     = push_req & fifo_full;
    assign has_cmd  = (fifo_count != '0) & ~fifo_empty;

    jtcontra_snd_fifo #(
        .FIFO_AW (FIFO_AW),
        .DW      (8)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_req),
        .pop   (pop),
        .din   (bus.main_din),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_next;
    end

    // A read in IRQ finishes the command outright; an ack alone parks in WAIT until the read.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        irq_release = 1'b0;
        case (state)
            ST_IDLE: begin
                if (has_cmd) begin
                    pop        = 1'b1;
                    state_next = ST_IRQ;
                end
            end
            ST_IRQ: begin
                if (bus.snd_cen && (bus.snd_irq_ack || bus.snd_rd)) begin
                    irq_release = 1'b1;
                    state_next  = bus.snd_rd ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.snd_cen && bus.snd_rd) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The latch only loads on a pop, so it is frozen for the whole IRQ / WAIT period.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_r <= 8'd0;
            irqn_r <= 1'b1;
        end else if (pop) begin
            dout_r <= fifo_head;
            irqn_r <= 1'b0;
        end else if (irq_release) begin
            irqn_r <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     ovf_r <= 8'd0;
        else if (drop) ovf_r <= ovf_inc(ovf_r);
    end

    assign bus.main_full = fifo_full;
    assign bus.snd_dout  = dout_r;
    assign bus.snd_irqn  = irqn_r;
    assign bus.ovf_cnt   = ovf_r;

endmodule

// File: tb/tb_jtcontra_snd_cmd.sv
// Directed bench for the sound command mailbox; expected command bytes are queued on
// each accepted write and checked whenever the sound IRQ falls.
module tb_jtcontra_snd_cmd;

    localparam int DEPTH = 4;

    logic clk;
    logic rstn;

    jtcontra_snd_cmd_if bus ();

    jtcontra_snd_cmd #(.FIFO_AW(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         irq_pulses = 0;
    logic [7:0] exp_q[$];
    logic [7:0] ovf_model = 8'd0;
    logic [7:0] last_latched = 8'd0;
    logic       prev_irqn = 1'b1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller sits just after a rising edge; the strobe is sampled on the next edge.
    task automatic write_cmd(input logic [7:0] b);
        bus.main_cen = 1'b1;
        bus.main_we  = 1'b1;
        bus.main_din = b;
        step();
        bus.main_cen = 1'b0;
        bus.main_we  = 1'b0;
        if (exp_q.size() >= DEPTH) begin
            if (ovf_model != 8'hFF) ovf_model = ovf_model + 8'd1;
        end else begin
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_irq(input string tag);
        for (int i = 0; i < 50 && bus.snd_irqn !== 1'b0; i++) step();
        check(tag, {7'd0, bus.snd_irqn}, 8'd0);
    endtask

    task automatic snd_cycle(input logic ack, input logic rd);
        bus.snd_cen     = 1'b1;
        bus.snd_irq_ack = ack;
        bus.snd_rd      = rd;
        step();
        bus.snd_cen     = 1'b0;
        bus.snd_irq_ack = 1'b0;
        bus.snd_rd      = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rstn && prev_irqn === 1'b1 && bus.snd_irqn === 1'b0) begin
            irq_pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_irq", 8'd1, 8'd0);
            end else begin
                last_latched = exp_q.pop_front();
                check("latched_byte", bus.snd_dout, last_latched);
            end
        end
        prev_irqn = bus.snd_irqn;
    end

    initial begin
        int pulses_before;
        int low_cycles;
        rstn            = 1'b0;
        bus.main_cen    = 1'b0;
        bus.main_we     = 1'b0;
        bus.main_din    = 8'd0;
        bus.snd_cen     = 1'b0;
        bus.snd_rd      = 1'b0;
        bus.snd_irq_ack = 1'b0;
        repeat (3) step();
        check("reset_irqn", {7'd0, bus.snd_irqn}, 8'd1);
        check("reset_dout", bus.snd_dout, 8'd0);
        check("reset_full", {7'd0, bus.main_full}, 8'd0);
        check("reset_ovf", bus.ovf_cnt, 8'd0);
        rstn = 1'b1;
        repeat (2) step();

        // Single command: latency, ack then read, and snd_rd gating by snd_cen.
        write_cmd(8'h2A);
        check("latency_irqn_high", {7'd0, bus.snd_irqn}, 8'd1);
        step();
        check("latency_irqn_low", {7'd0, bus.snd_irqn}, 8'd0);
        check("latency_dout", bus.snd_dout, 8'h2A);
        snd_cycle(1'b1, 1'b0);
        check("ack_irqn", {7'd0, bus.snd_irqn}, 8'd1);
        bus.snd_rd = 1'b1;
        write_cmd(8'h55);
        repeat (4) step();
        bus.snd_rd = 1'b0;
        check("rd_no_cen_irqn", {7'd0, bus.snd_irqn}, 8'd1);
        check("wait_dout_held", bus.snd_dout, last_latched);
        snd_cycle(1'b0, 1'b1);
        check("gap_irqn", {7'd0, bus.snd_irqn}, 8'd1);
        step();
        check("next_irqn", {7'd0, bus.snd_irqn}, 8'd0);
        snd_cycle(1'b1, 1'b1);
        check("ackrd_irqn", {7'd0, bus.snd_irqn}, 8'd1);
        step();
        check("single_ovf", bus.ovf_cnt, ovf_model);

        // main_we without main_cen must never push.
        bus.main_we  = 1'b1;
        bus.main_din = 8'h77;
        repeat (50) step();
        bus.main_we  = 1'b0;
        check("gate_irqn", {7'd0, bus.snd_irqn}, 8'd1);
        check("gate_full", {7'd0, bus.main_full}, 8'd0);

        // Burst with sound idle: one byte latched, so the fifth write fills the FIFO.
        pulses_before = irq_pulses;
        for (int i = 1; i <= 4; i++) write_cmd(8'(i));
        check("burst4_full", {7'd0, bus.main_full}, {7'd0, exp_q.size() == DEPTH});
        write_cmd(8'h05);
        check("burst5_full", {7'd0, bus.main_full}, {7'd0, exp_q.size() == DEPTH});
        write_cmd(8'hEE);
        check("drop_ovf", bus.ovf_cnt, ovf_model);
        check("drop_full", {7'd0, bus.main_full}, 8'd1);
        for (int i = 0; i < 5; i++) begin
            wait_irq("burst_irq_timeout");
            snd_cycle(1'b1, 1'b0);
            check("burst_ack_dout", bus.snd_dout, last_latched);
            snd_cycle(1'b0, 1'b1);
        end
        repeat (4) step();
        check("burst_pulses", 8'(irq_pulses - pulses_before), 8'd5);
        check("burst_drained", 8'(exp_q.size()), 8'd0);

        // Saturation of the drop counter.
        for (int i = 0; i < 5; i++) write_cmd(8'h10 + 8'(i));
        for (int i = 0; i < 300; i++) write_cmd(8'hEE);
        check("sat_ovf", bus.ovf_cnt, ovf_model);
        check("sat_irqn_pending", {7'd0, bus.snd_irqn}, 8'd0);

        // Asynchronous reset in the middle of a handshake.
        #5;
        rstn = 1'b0;
        #1;
        check("async_irqn", {7'd0, bus.snd_irqn}, 8'd1);
        check("async_dout", bus.snd_dout, 8'd0);
        check("async_full", {7'd0, bus.main_full}, 8'd0);
        check("async_ovf", bus.ovf_cnt, 8'd0);
        exp_q.delete();
        ovf_model = 8'd0;
        repeat (2) step();
        rstn = 1'b1;
        low_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.snd_irqn !== 1'b1) low_cycles++;
        end
        check("post_reset_quiet", 8'(low_cycles), 8'd0);

        // Push and pop on the same edge at count 2, after a combined ack+read.
        write_cmd(8'hA1);
        write_cmd(8'hA2);
        write_cmd(8'hA3);
        wait_irq("simul_irq_timeout");
        snd_cycle(1'b1, 1'b1);
        write_cmd(8'hA4);
        check("simul_irqn", {7'd0, bus.snd_irqn}, 8'd0);
        write_cmd(8'hA5);
        write_cmd(8'hA6);
        check("simul_full", {7'd0, bus.main_full}, 8'd1);
        write_cmd(8'hA7);
        check("simul_ovf", bus.ovf_cnt, ovf_model);
        for (int i = 0; i < 5; i++) begin
            wait_irq("simul_drain_timeout");
            snd_cycle(1'b1, 1'b1);
        end
        repeat (4) step();
        check("simul_drained", 8'(exp_q.size()), 8'd0);
        check("simul_final_irqn", {7'd0, bus.snd_irqn}, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
